// File: rtl/rv_muldiv.sv
// rv_muldiv: iterative RISC-V M-extension execute unit
// (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
//
// Build option:
//   RV_MULDIV_FAST_MUL_EN
//     Defined:   the four multiply ops use a single-cycle combinational
//                multiplier and go IDLE -> FIX -> DONE.
//     Undefined: every op uses the one-bit-per-cycle datapath, and no
//                hardware multiplier is inferred.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   in_valid/ready  request handshake. in_ready is high only in IDLE.
//   in_op           funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU,
//                           4 DIV, 5 DIVU, 6 REM, 7 REMU
//   in_a, in_b      rs1 / rs2 values, captured at accept
//   in_tag          rd index. It is passed through unchanged to out_tag.
//   kill            abort the in-flight op while in BUSY or FIX
//   out_valid/ready result handshake. out_valid is high only in DONE.
//   out_result      XLEN-bit result
//   out_tag         tag of the result
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A request is accepted only in IDLE when kill is low. A result
// is offered in DONE, and out_result/out_tag stay stable until the consumer
// takes it. Nothing is accepted in the cycle that the result leaves.
module rv_muldiv #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CNT_W = $clog2(XLEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // acc_q holds {hi, lo}. For a multiply it is {partial product, multiplier}.
  // For a divide it is {partial remainder, dividend/quotient}.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_mag_q, b_mag_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              special_q, special_d;
  logic [XLEN-1:0]   result_q, result_d;

  // ---------------- request decode ----------------
  logic            accept;
  logic            is_div_in, a_signed_in, b_signed_in;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special_in, fast_mul_in;
  logic [XLEN-1:0] special_val;

  always_comb begin
    accept      = in_valid && in_ready && !kill;
    is_div_in   = in_op[2];
    a_signed_in = (in_op == 3'd1) || (in_op == 3'd2) ||
                  (in_op == 3'd4) || (in_op == 3'd6);
    b_signed_in = (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);
    // The sign bit of the operand after it is extended to XLEN+1 bits.
    a_neg       = a_signed_in && in_a[XLEN-1];
    b_neg       = b_signed_in && in_b[XLEN-1];
    // The magnitude of an (XLEN+1)-bit signed value always fits in XLEN bits.
    a_mag       = a_neg ? -in_a : in_a;
    b_mag       = b_neg ? -in_b : in_b;
    div_zero    = (in_b == '0);
    div_ovf     = ((in_op == 3'd4) || (in_op == 3'd6)) &&
                  (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);
    special_in  = is_div_in && (div_zero || div_ovf);
    // in_op[1] selects REM/REMU over DIV/DIVU.
    special_val = '0;
    if (div_zero) begin
      special_val = in_op[1] ? in_a : '1;
    end else if (div_ovf) begin
      special_val = in_op[1] ? '0 : in_a;
    end
`ifdef RV_MULDIV_FAST_MUL_EN
    fast_mul_in = !is_div_in;
`else
    fast_mul_in = 1'b0;
`endif
  end

`ifdef RV_MULDIV_FAST_MUL_EN
  // Both operands are sign-extended to 2*XLEN bits, so the low 2*XLEN bits
  // of an unsigned product equal the exact signed product.
  logic [2*XLEN-1:0] a_sx, b_sx, fast_prod;
  always_comb begin
    a_sx      = {{XLEN{a_neg}}, in_a};
    b_sx      = {{XLEN{b_neg}}, in_b};
    fast_prod = a_sx * b_sx;
  end
`endif

  // ---------------- iterative datapath ----------------
  logic [XLEN-1:0]   acc_hi, acc_lo;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_val;

  always_comb begin
    acc_hi    = acc_q[2*XLEN-1:XLEN];
    acc_lo    = acc_q[XLEN-1:0];
    // Shift-add: add the multiplicand when the multiplier LSB is set, then
    // shift the combined accumulator right by one bit.
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag_q} : '0);
    mul_next  = {mul_sum, acc_lo[XLEN-1:1]};
    // Restoring step: bring in the next dividend bit, and subtract the
    // divisor when it fits. The quotient bit enters at the LSB.
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, b_mag_q});
    div_rem   = div_ge ? XLEN'(div_shift - {1'b0, b_mag_q}) : div_shift[XLEN-1:0];
    div_next  = {div_rem, acc_lo[XLEN-2:0], div_ge};
    // Sign correction and result selection, applied in FIX.
    prod      = neg_res_q ? -acc_q : acc_q;
    quot_fix  = neg_res_q ? -acc_lo : acc_lo;
    rem_fix   = neg_rem_q ? -acc_hi : acc_hi;
    if (op_q[2]) begin
      fix_val = op_q[1] ? rem_fix : quot_fix;
    end else begin
      fix_val = (op_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      tag_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_mag_q   <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      special_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_mag_q   <= b_mag_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      special_q <= special_d;
      result_q  <= result_d;
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (special_in || fast_mul_in) ? S_FIX : S_BUSY;
      S_BUSY: begin
        if (kill) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX:  state_d = kill ? S_IDLE : S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    op_d      = op_q;
    tag_d     = tag_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_mag_d   = b_mag_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    special_d = special_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d      = in_op;
          tag_d     = in_tag;
          cnt_d     = CNT_W'(XLEN);
          acc_d     = {{XLEN{1'b0}}, a_mag};
          b_mag_d   = b_mag;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          special_d = special_in;
          if (special_in) result_d = special_val;
`ifdef RV_MULDIV_FAST_MUL_EN
          if (fast_mul_in) begin
            // The product is already signed, so FIX must not negate it.
            acc_d     = fast_prod;
            neg_res_d = 1'b0;
          end
`endif
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        acc_d = op_q[2] ? div_next : mul_next;
      end
      S_FIX: begin
        if (!special_q) result_d = fix_val;
      end
      default: ;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    in_ready   = (state_q == S_IDLE);
    out_valid  = (state_q == S_DONE);
    out_result = result_q;
    out_tag    = tag_q;
  end

endmodule

// File: tb/tb_rv_muldiv.sv
// Directed testbench for rv_muldiv (XLEN=32). A reference model derived
// from the RISC-V M-extension rules fills the expected queue. A monitor
// compares every valid output cycle with that queue, and drivers also check
// hand-computed literals, latency and handshake behaviour.
module tb_rv_muldiv;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_op = '0;
  logic [XLEN-1:0]  in_a = '0;
  logic [XLEN-1:0]  in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             kill = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  rv_muldiv #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [XLEN-1:0]  exp_q[$];
  logic [TAG_W-1:0] exp_tag_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0]        ua, ub, up;
    logic               ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin sp = sa * sb; return sp[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        sp = sa / sb; return sp[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        up = ua / ub; return up[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        sp = sa % sb; return sp[31:0];
      end
      default: begin
        if (b == 0) return a;
        up = ua % ub; return up[31:0];
      end
    endcase
  endfunction

  // Number of edges from the accept edge to the first out_valid.
  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (op[2] && ((b == 0) || (((op == 3'd4) || (op == 3'd6)) &&
                               (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF))))
      return 1;
`ifdef RV_MULDIV_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return XLEN + 1;
  endfunction

  // Monitor: every cycle with out_valid high must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got result 0x%0h tag %0d with nothing expected",
                 out_result, out_tag);
      end else begin
        check("mon_result", out_result, exp_q[0]);
        check("mon_tag", out_tag, exp_tag_q[0]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(exp_tag_q.pop_front());
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Issues one op, checks latency and handshake, optionally checks a literal
  // result, holds the result for `hold` cycles, then consumes it.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input logic use_lit,
                        input logic [31:0] lit, input int hold, input logic kill_in_done);
    int n;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    exp_q.push_back(model(op, a, b));
    exp_tag_q.push_back(tag);
    @(posedge clk); #1;
    // Scramble the inputs to show that the op uses only the values captured at accept.
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom;
    in_tag = TAG_W'($urandom); in_op = 3'($urandom);
    n = 0;
    while (!out_valid && n < 100) begin
      check("in_ready_busy", in_ready, 0);
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL timeout: op %0d got no out_valid within 100 edges", op);
      exp_q.delete();
      exp_tag_q.delete();
      pulse_reset();
      return;
    end
    check("latency", n, exp_lat(op, a, b));
    if (use_lit) check("result_literal", out_result, lit);
    check("tag_literal", out_tag, tag);
    for (int i = 0; i < hold; i++) begin
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
      kill = kill_in_done && (i == 0);
      @(posedge clk); #1;
      kill = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready_after", in_ready, 1);
    check("out_valid_after", out_valid, 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  // Starts an op that is expected to be abandoned. Nothing is queued.
  task automatic start_only(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = 5'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check(name, seen, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_tag", out_tag, 0);
    rst = 1'b0;

    // Multiply, including 5 cycles of backpressure.
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 1'b1, 32'hFFFF_FFEB, 5, 1'b0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, 1'b1, 32'h4000_0000, 0, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1'b1, 32'hFFFF_FFFE, 1, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b1, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(3'd0, 32'd0, 32'h0001_2345, 5'd7, 1'b1, 32'd0, 0, 1'b0);

    // Divide and remainder.
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd8, 1'b1, 32'hFFFF_FFFD, 0, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b1, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(3'd5, 32'd100, 32'd7, 5'd11, 1'b1, 32'd14, 2, 1'b0);
    run_op(3'd7, 32'd100, 32'd7, 5'd12, 1'b1, 32'd2, 0, 1'b0);

    // Special cases finish one edge after accept.
    run_op(3'd4, 32'd5, 32'd0, 5'd13, 1'b1, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(3'd7, 32'd5, 32'd0, 5'd14, 1'b1, 32'd5, 0, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b1, 32'h8000_0000, 0, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1'b1, 32'd0, 3, 1'b0);

    // kill in DONE is ignored, so the result is still delivered.
    run_op(3'd5, 32'd1000, 32'd3, 5'd17, 1'b1, 32'd333, 2, 1'b1);

    // kill pulse sampled at BUSY step 10.
    start_only(3'd5, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_in_ready", in_ready, 1);
    check("kill_out_valid", out_valid, 0);
    expect_quiet("kill_no_result", 40);

    // kill together with in_valid in IDLE: the request is not accepted.
    @(negedge clk);
    in_valid = 1'b1; kill = 1'b1; in_op = 3'd4; in_a = 32'd5; in_b = 32'd0;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    check("kill_idle_in_ready", in_ready, 1);
    expect_quiet("kill_idle_no_result", 4);

    // Reset in the middle of BUSY.
    start_only(3'd4, 32'd12345, 32'd67);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_result", out_result, 0);
    check("midrst_out_tag", out_tag, 0);
    rst = 1'b0;
    expect_quiet("midrst_no_result", 40);

    // Model-checked vectors with random operands.
    for (int i = 0; i < 16; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      run_op(op, a, b, 5'($urandom_range(0, 31)), 1'b0, 32'd0,
             $urandom_range(0, 2), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #1000000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
